// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if -- request/grant bundle between the three SRAM clients and
// the arbiter.
//
// Signals (N = 0..2; port 0 = VGA read, port 1 = dark engine, port 2 = blur engine)
//   pN_req    client -> arbiter  access request, held until pN_gnt is seen high
//   pN_we     client -> arbiter  1 = write, 0 = read
//   pN_addr   client -> arbiter  SRAM word address (AW bits)
//   pN_wdata  client -> arbiter  write data (DW bits)
//   pN_gnt    arbiter -> client  request accepted this cycle (combinational, one-hot)
//   pN_rvalid arbiter -> client  read data for port N valid (registered, 1-cycle pulse)
//   rdata     arbiter -> clients registered read data, shared by all ports
//
// Modports: master = client side, slave = arbiter side.
interface sram_arbiter_if #(
  parameter int AW = 20,
  parameter int DW = 16
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;

  logic          p2_req;
  logic          p2_we;
  logic [AW-1:0] p2_addr;
  logic [DW-1:0] p2_wdata;
  logic          p2_gnt;
  logic          p2_rvalid;

  logic [DW-1:0] rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output p2_req, p2_we, p2_addr, p2_wdata,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, p2_gnt, p2_rvalid,
    input  rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  p2_req, p2_we, p2_addr, p2_wdata,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, p2_gnt, p2_rvalid,
    output rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter -- three-port arbiter in front of a single asynchronous SRAM.
// Port 0 has priority; ports 1 and 2 share round-robin and are protected from
// starvation by a saturating counter of consecutive port-0 grants. One access
// is issued per cycle: grant in cycle N, SRAM phase in N+1, read data and
// rvalid in N+2.
//
// Ports
//   avm_clk      in     sole clock, rising edge
//   avm_rst      in     synchronous active-high reset
//   bus          slave  request/grant/read-data bundle (sram_arbiter_if)
//   o_SRAM_ADDR  out    registered SRAM address (holds in IDLE)
//   io_SRAM_DQ   inout  SRAM data, driven only in a WRITE phase
//   o_SRAM_WE_N  out    write enable, low in WRITE phase
//   o_SRAM_OE_N  out    output enable, high in WRITE phase
//   o_SRAM_CE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  tied low
module sram_arbiter #(
  parameter int AW           = 20,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          avm_clk,
  input  logic          avm_rst,
  sram_arbiter_if.slave bus,
  output logic [AW-1:0] o_SRAM_ADDR,
  inout  wire  [DW-1:0] io_SRAM_DQ,
  output logic          o_SRAM_WE_N,
  output logic          o_SRAM_CE_N,
  output logic          o_SRAM_OE_N,
  output logic          o_SRAM_LB_N,
  output logic          o_SRAM_UB_N
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} phase_t;

  phase_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [1:0]    rr_last;
  logic [2:0]    gnt;
  logic [1:0]    rr_pick;
  logic          req12;
  logic          starved;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    owner_q;
  logic [2:0]    rvalid_q;
  logic [DW-1:0] rdata_q;
  logic          drive_dq;

  always_ff @(posedge avm_clk) begin
    if (avm_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Arbitration, next phase and starvation bookkeeping. rr_pick is the port
  // 1/2 winner (0 = neither requests); it only pre-empts port 0 once port 0
  // has been granted STARVE_LIMIT times in a row while 1 or 2 waited.
  always_comb begin
    gnt        = 3'b000;
    rr_pick    = 2'd0;
    state_nxt  = IDLE;
    starve_nxt = starve_cnt;
    sel_we     = bus.p0_we;
    sel_addr   = bus.p0_addr;
    sel_wdata  = bus.p0_wdata;

    req12   = bus.p1_req | bus.p2_req;
    starved = (starve_cnt == SW'(STARVE_LIMIT)) && req12;

    if (bus.p1_req && bus.p2_req) rr_pick = (rr_last == 2'd1) ? 2'd2 : 2'd1;
    else if (bus.p1_req)          rr_pick = 2'd1;
    else if (bus.p2_req)          rr_pick = 2'd2;

    if (!avm_rst) begin
      if (bus.p0_req && !starved) gnt = 3'b001;
      else if (rr_pick == 2'd1)   gnt = 3'b010;
      else if (rr_pick == 2'd2)   gnt = 3'b100;
    end

    if (gnt[1]) begin
      sel_we    = bus.p1_we;
      sel_addr  = bus.p1_addr;
      sel_wdata = bus.p1_wdata;
    end else if (gnt[2]) begin
      sel_we    = bus.p2_we;
      sel_addr  = bus.p2_addr;
      sel_wdata = bus.p2_wdata;
    end

    if (gnt != 3'b000) state_nxt = sel_we ? WRITE : READ;

    if (!req12 || gnt[1] || gnt[2])
      starve_nxt = '0;
    else if (gnt[0] && (starve_cnt != SW'(STARVE_LIMIT)))
      starve_nxt = starve_cnt + SW'(1);
  end

  // Datapath registers. owner_q is kept one-hot so the read completing in
  // the READ phase can be steered straight onto the matching rvalid bit.
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      starve_cnt <= '0;
      rr_last    <= 2'd2;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_q    <= 3'b000;
      rvalid_q   <= 3'b000;
      rdata_q    <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      if (gnt[1])      rr_last <= 2'd1;
      else if (gnt[2]) rr_last <= 2'd2;
      if (gnt != 3'b000) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        owner_q <= gnt;
      end
      rvalid_q <= 3'b000;
      if (state == READ) begin
        rdata_q  <= io_SRAM_DQ;
        rvalid_q <= owner_q;
      end
    end
  end

  // A WRITE phase left over when reset asserts must not keep driving DQ.
  assign drive_dq    = (state == WRITE) && !avm_rst;
  assign io_SRAM_DQ  = drive_dq ? wdata_q : {DW{1'bz}};
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = ~drive_dq;
  assign o_SRAM_OE_N = drive_dq;
  assign o_SRAM_CE_N = 1'b0;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;

  assign bus.p0_gnt    = gnt[0];
  assign bus.p1_gnt    = gnt[1];
  assign bus.p2_gnt    = gnt[2];
  assign bus.p0_rvalid = rvalid_q[0];
  assign bus.p1_rvalid = rvalid_q[1];
  assign bus.p2_rvalid = rvalid_q[2];
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter -- self-checking bench for sram_arbiter. A behavioural
// model (grant rules, SRAM memory, pending read) predicts every output each
// cycle; directed sequences pin the model with literal expectations, then a
// long randomized run with occasional resets is checked against the model.
module tb_sram_arbiter;
  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int LIMIT = 8;

  typedef enum int {M_IDLE, M_READ, M_WRITE} mphase_e;

  logic avm_clk = 1'b0;
  logic avm_rst = 1'b1;
  always #5 avm_clk = ~avm_clk;

  logic [2:0]    req;
  logic [2:0]    we;
  logic [AW-1:0] addr  [3];
  logic [DW-1:0] wdata [3];

  sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  assign bus.p0_req   = req[0];
  assign bus.p0_we    = we[0];
  assign bus.p0_addr  = addr[0];
  assign bus.p0_wdata = wdata[0];
  assign bus.p1_req   = req[1];
  assign bus.p1_we    = we[1];
  assign bus.p1_addr  = addr[1];
  assign bus.p1_wdata = wdata[1];
  assign bus.p2_req   = req[2];
  assign bus.p2_we    = we[2];
  assign bus.p2_addr  = addr[2];
  assign bus.p2_wdata = wdata[2];

  wire  [DW-1:0] sram_dq;
  logic [AW-1:0] sram_addr;
  logic          we_n, ce_n, oe_n, lb_n, ub_n;

  sram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .avm_clk     (avm_clk),
    .avm_rst     (avm_rst),
    .bus         (bus),
    .o_SRAM_ADDR (sram_addr),
    .io_SRAM_DQ  (sram_dq),
    .o_SRAM_WE_N (we_n),
    .o_SRAM_CE_N (ce_n),
    .o_SRAM_OE_N (oe_n),
    .o_SRAM_LB_N (lb_n),
    .o_SRAM_UB_N (ub_n)
  );

  wire [2:0] gntV = {bus.p2_gnt, bus.p1_gnt, bus.p0_gnt};
  wire [2:0] rvV  = {bus.p2_rvalid, bus.p1_rvalid, bus.p0_rvalid};

  // Model state describing the current cycle; n* holds the next cycle.
  mphase_e       mPhase  = M_IDLE, nPhase  = M_IDLE;
  logic [AW-1:0] mAddr   = '0,     nAddr   = '0;
  logic [DW-1:0] mWdata  = '0,     nWdata  = '0;
  logic [DW-1:0] mRdata  = '0,     nRdata  = '0;
  logic [DW-1:0] mDq     = '0,     nDq     = '0;
  logic [2:0]    mRvalid = '0,     nRvalid = '0;
  int            mOwner  = 0,      nOwner  = 0;
  int            mStarve = 0,      nStarve = 0;
  int            mRr     = 2,      nRr     = 2;
  bit            armed   = 1'b0;
  int            lastGrant = -1;
  logic [DW-1:0] mem [int];

  int nCompared   = 0;
  int nMismatched = 0;

  // The SRAM model drives DQ whenever the arbiter must not.
  assign sram_dq = (avm_rst || mPhase != M_WRITE) ? mDq : {DW{1'bz}};

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int pickGrant(input logic [2:0] r, input int starve, input int rr);
    int w;
    w = -1;
    if (r[1] && r[2]) w = (rr == 1) ? 2 : 1;
    else if (r[1])    w = 1;
    else if (r[2])    w = 2;
    if (r[0] && !(starve == LIMIT && w >= 0)) return 0;
    return w;
  endfunction

  function automatic logic [DW-1:0] memRead(input logic [AW-1:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return DW'(a) ^ 16'h5A5A;
  endfunction

  always @(negedge avm_clk) begin
    mphase_e    ph;
    int         g;
    logic [2:0] expG;
    ph   = avm_rst ? M_IDLE : mPhase;
    g    = avm_rst ? -1 : pickGrant(req, mStarve, mRr);
    expG = (g < 0) ? 3'b000 : 3'(1 << g);
    if (armed) begin
      checkOutput("gnt",    gntV, expG);
      checkOutput("addr",   sram_addr, mAddr);
      checkOutput("we_n",   we_n, ph != M_WRITE);
      checkOutput("oe_n",   oe_n, ph == M_WRITE);
      checkOutput("ce_lb_ub", {ce_n, lb_n, ub_n}, 3'b000);
      checkOutput("dq",     sram_dq, (ph == M_WRITE) ? mWdata : mDq);
      checkOutput("rvalid", rvV, mRvalid);
      checkOutput("rdata",  bus.rdata, mRdata);
    end
    if (avm_rst) begin
      nPhase = M_IDLE; nAddr = '0; nWdata = '0; nRdata = '0; nRvalid = '0;
      nOwner = 0; nStarve = 0; nRr = 2;
      nDq = DW'($urandom);
    end else begin
      nRvalid = '0;
      nRdata  = mRdata;
      if (ph == M_READ) begin
        nRvalid[mOwner] = 1'b1;
        nRdata = mDq;
      end
      if (ph == M_WRITE) mem[int'(mAddr)] = mWdata;
      if (g == 1 || g == 2 || !(req[1] || req[2])) nStarve = 0;
      else if (g == 0) nStarve = (mStarve < LIMIT) ? mStarve + 1 : LIMIT;
      else             nStarve = mStarve;
      nRr = (g == 1 || g == 2) ? g : mRr;
      if (g >= 0) begin
        nPhase = we[g] ? M_WRITE : M_READ;
        nAddr  = addr[g];
        nWdata = wdata[g];
        nOwner = g;
      end else begin
        nPhase = M_IDLE;
        nAddr  = mAddr;
        nWdata = mWdata;
        nOwner = mOwner;
      end
      nDq = (nPhase == M_READ) ? memRead(nAddr) : DW'($urandom);
    end
    lastGrant = g;
  end

  always @(posedge avm_clk) begin
    if (avm_rst) armed <= 1'b1;
    mPhase  <= nPhase;
    mAddr   <= nAddr;
    mWdata  <= nWdata;
    mRdata  <= nRdata;
    mDq     <= nDq;
    mRvalid <= nRvalid;
    mOwner  <= nOwner;
    mStarve <= nStarve;
    mRr     <= nRr;
  end

  task automatic tick();
    @(posedge avm_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge avm_clk);
  endtask

  task automatic applyStimulus(input int p, input logic r, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]   = r;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  function automatic logic [1:0] gntIndex(input logic [2:0] v);
    case (v)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  initial begin
    logic [63:0] seqAct;
    logic [63:0] seqExp;
    int          rate0;
    int          rate12;

    for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, 1'b0, '0, '0);
    avm_rst = 1'b1;
    tick();
    tick();
    applyStimulus(0, 1'b1, 1'b0, 20'h00005, '0);
    sample();
    checkOutput("rst_gnt",  gntV, 3'b000);
    checkOutput("rst_we_n", we_n, 1'b1);
    checkOutput("rst_oe_n", oe_n, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    tick();
    avm_rst = 1'b0;

    // p0 read of 0x00010 returning 0xABCD
    mem[32'h10] = 16'hABCD;
    applyStimulus(0, 1'b1, 1'b0, 20'h00010, '0);
    sample();
    checkOutput("r031_gnt",      gntV, 3'b001);
    checkOutput("r031_addr_rst", sram_addr, '0);
    checkOutput("r031_rdata_rst", bus.rdata, '0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    sample();
    checkOutput("r031_addr", sram_addr, 20'h00010);
    checkOutput("r031_oe_n", oe_n, 1'b0);
    tick();
    sample();
    checkOutput("r031_rvalid", rvV, 3'b001);
    checkOutput("r031_rdata",  bus.rdata, 16'hABCD);

    // p1 write of 0x1234 to 0x00020
    tick();
    applyStimulus(1, 1'b1, 1'b1, 20'h00020, 16'h1234);
    sample();
    checkOutput("r032_gnt", gntV, 3'b010);
    tick();
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    sample();
    checkOutput("r032_we_n", we_n, 1'b0);
    checkOutput("r032_oe_n", oe_n, 1'b1);
    checkOutput("r032_dq",   sram_dq, 16'h1234);
    tick();
    sample();
    checkOutput("r032_rvalid", rvV, 3'b000);
    checkOutput("r032_rdata",  bus.rdata, 16'hABCD);

    // write then immediate read of the same address by another port
    tick();
    applyStimulus(2, 1'b1, 1'b1, 20'h00030, 16'hBEEF);
    sample();
    checkOutput("r036_wgnt", gntV, 3'b100);
    tick();
    applyStimulus(2, 1'b0, 1'b0, '0, '0);
    applyStimulus(0, 1'b1, 1'b0, 20'h00030, '0);
    sample();
    checkOutput("r036_rgnt", gntV, 3'b001);
    checkOutput("r036_wdq",  sram_dq, 16'hBEEF);
    tick();
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    sample();
    checkOutput("r036_rd_we_n", we_n, 1'b1);
    checkOutput("r036_rd_oe_n", oe_n, 1'b0);
    tick();
    sample();
    checkOutput("r036_rvalid", rvV, 3'b001);
    checkOutput("r036_rdata",  bus.rdata, 16'hBEEF);

    // reset in the cycle after a p2 read grant discards the read
    tick();
    applyStimulus(2, 1'b1, 1'b0, 20'h00040, '0);
    sample();
    checkOutput("r035_gnt", gntV, 3'b100);
    tick();
    applyStimulus(2, 1'b0, 1'b0, '0, '0);
    avm_rst = 1'b1;
    sample();
    checkOutput("r035_we_n", we_n, 1'b1);
    checkOutput("r035_oe_n", oe_n, 1'b0);
    tick();
    avm_rst = 1'b0;
    sample();
    checkOutput("r035_rvalid_a", rvV, 3'b000);
    checkOutput("r035_rdata",    bus.rdata, '0);
    tick();
    sample();
    checkOutput("r035_rvalid_b", rvV, 3'b000);

    // p1 and p2 alternate starting with p1 after reset
    tick();
    applyStimulus(1, 1'b1, 1'b0, 20'h00100, '0);
    applyStimulus(2, 1'b1, 1'b0, 20'h00200, '0);
    seqAct = '0;
    seqExp = '0;
    for (int i = 0; i < 6; i++) begin
      sample();
      seqAct[2*i +: 2] = gntIndex(gntV);
      seqExp[2*i +: 2] = (i % 2 == 0) ? 2'd1 : 2'd2;
      tick();
    end
    checkOutput("r034_seq", seqAct, seqExp);

    // all three requesting: 8 x p0, p1, 8 x p0, p2, p0, p0
    applyStimulus(0, 1'b1, 1'b0, 20'h00300, '0);
    seqAct = '0;
    seqExp = '0;
    for (int i = 0; i < 20; i++) begin
      sample();
      seqAct[2*i +: 2] = gntIndex(gntV);
      seqExp[2*i +: 2] = (i == 8) ? 2'd1 : ((i == 17) ? 2'd2 : 2'd0);
      tick();
    end
    checkOutput("r033_seq", seqAct, seqExp);
    for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, 1'b0, '0, '0);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      rate0  = (c < 1500) ? 90 : 30;
      rate12 = (c < 1500) ? 40 : 60;
      avm_rst = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < 3; p++) begin
        if (!req[p] || lastGrant == p) begin
          if (int'($urandom_range(0, 99)) < ((p == 0) ? rate0 : rate12))
            applyStimulus(p, 1'b1, 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 15)), DW'($urandom));
          else
            applyStimulus(p, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    avm_rst = 1'b0;
    for (int p = 0; p < 3; p++) applyStimulus(p, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter AW, 20, SRAM address width.
REQ-002 Parameter DW, 16, SRAM data width.
REQ-003 Parameter STARVE_LIMIT, 8, max consecutive port-0 grants while port 1 or 2 waits.
REQ-004 Clock and reset: one clock, avm_clk; reset avm_rst is synchronous and active-high.
REQ-005 avm_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 avm_rst  input  1  synchronous active-high reset.
REQ-007 pN_req  input  1  port N (N=0..2) access request; port 0 = VGA read, port 1 = dark engine, port 2 = blur engine.
REQ-008 pN_we  input  1  port N access type: 1 = write, 0 = read.
REQ-009 pN_addr  input  AW  port N word address.
REQ-010 pN_wdata  input  DW  port N write data.
REQ-011 pN_gnt  output  1  port N request accepted this cycle (combinational, one-hot).
REQ-012 pN_rvalid  output  1  read data for port N valid (registered, 1-cycle pulse).
REQ-013 rdata  output  DW  registered read data, shared by all ports.
REQ-014 o_SRAM_ADDR  output  AW; io_SRAM_DQ  inout  DW; o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  output  1 each.

Function
REQ-015 At most one grant per cycle; a grant is issued only to a port whose req is high in that cycle.
REQ-016 Priority: port 0 wins unless starve_cnt == STARVE_LIMIT; otherwise port 1/2 chosen round-robin by rr_last.
REQ-017 starve_cnt (0..STARVE_LIMIT) increments on each port-0 grant while p1_req or p2_req is high, clears on any port-1/2 grant or when p1_req and p2_req are both low, and saturates.
REQ-018 When starve_cnt == STARVE_LIMIT and p1_req or p2_req is high, the round-robin winner of ports 1/2 is granted instead of port 0.
REQ-019 Round-robin: rr_last records the last granted port of 1/2; when both request, the other port wins; when only one requests, it wins; rr_last is unchanged on port-0 grants.
REQ-020 Phase state machine (registered): IDLE, READ, WRITE; next state is READ/WRITE on a grant with we=0/1, else IDLE.
REQ-021 In cycle N+1 after a grant in cycle N: o_SRAM_ADDR = registered address; WRITE: WE_N=0, OE_N=1, DQ driven with registered wdata; READ/IDLE: WE_N=1, OE_N=0, DQ high-Z.
REQ-022 CE_N, LB_N and UB_N are constant 0; o_SRAM_ADDR holds its last value in IDLE.
REQ-023 READ phase: io_SRAM_DQ is sampled at the end of cycle N+1 into rdata; pN_rvalid of the owning port is 1 in cycle N+2 only.
REQ-024 Read latency is grant + 2 cycles; throughput is one access per cycle, and back-to-back grants to any mix of ports are legal.
REQ-025 A write produces no rvalid; rdata holds its value until the next read completes.
REQ-026 Requests are not queued; a requester holds req, we, addr and wdata stable until its gnt is sampled high.
REQ-027 DQ is never driven in a READ phase following a WRITE phase; no turnaround cycle is inserted.

Reset
REQ-028 While avm_rst=1 at a clock edge: state=IDLE, starve_cnt=0, rr_last=2, rdata=0, all rvalid=0, registered addr=0, registered wdata=0.
REQ-029 During reset all gnt outputs are 0, WE_N=1, OE_N=0, and DQ is high-Z.
REQ-030 A read in flight when reset asserts is discarded; no rvalid is issued after reset deasserts.

Verification
REQ-031 p0 read, addr 0x00010, SRAM returns 0xABCD -> p0_gnt in cycle 0, ADDR=0x00010 in cycle 1, p0_rvalid=1 and rdata=0xABCD in cycle 2.
REQ-032 p1 write, addr 0x00020, data 0x1234 -> p1_gnt in cycle 0; in cycle 1 WE_N=0, OE_N=1, DQ=0x1234; no rvalid.
REQ-033 p0, p1 and p2 all held requesting for 20 cycles with STARVE_LIMIT=8 -> 8 p0 grants, then 1 p1 grant, then 8 p0 grants, then 1 p2 grant.
REQ-034 p1 and p2 requesting continuously with p0 idle -> grants alternate p1, p2, p1, ... starting with p1 after reset.
REQ-035 avm_rst asserted in the cycle after a p2 read grant -> p2_rvalid stays 0, DQ high-Z, state=IDLE.
REQ-036 Write to addr A in cycle 0, then read of A by another port in cycle 1 -> read returns the written data, and DQ is high-Z in the read phase.
